mux2_arb: RTL
=============

Name: mux2_arb

Overview:
- Upstream stage of the team's 2:1 mux component. Arbitrates between two valid/ready input streams and drives the mux select `sel` (1 = in1, 0 = in2).
- Registers the chosen word into a single output slot.
- Round-robin fairness with a bounded burst per owner, so one requester cannot starve the other.
- Replaces a free-running or software-driven select when two sources share one downstream consumer.

Parameters:
- DATA_W, 8, width of in1, in2 and out.
- MAX_BURST, 4, max consecutive transfers by the current owner while the other input is valid; legal range 1..255.

Ports:
- sys_clk  input  1  clock; all state updates on rising edge.
- sys_rst  input  1  asynchronous, active-high reset.
- in1  input  DATA_W  source 1 data.
- in1_valid  input  1  source 1 has data.
- in1_ready  output  1  source 1 word accepted this cycle when in1_valid is also high.
- in2  input  DATA_W  source 2 data.
- in2_valid  input  1  source 2 has data.
- in2_ready  output  1  source 2 acceptance, same rule as in1_ready.
- sel  output  1  registered owner; 1 = in1, 0 = in2; feeds the downstream 2:1 mux select.
- out  output  DATA_W  registered data.
- out_valid  output  1  out holds a word.
- out_ready  input  1  consumer accepts out this cycle.

Behaviour:
- Reset values (async assert, sync release): state=IDLE, sel=1, out=0, out_valid=0, burst_cnt=0, rr_last=in2 (so in1 wins the first tie). in1_ready=in2_ready=0 while reset is high.
- load = ~out_valid | out_ready. The output slot refills in the same cycle it drains, giving full throughput.
- State IDLE: both readies low.
  - If any input valid: grant per round-robin (the input not equal to rr_last wins a tie; a lone valid wins outright).
  - Next cycle: state=SERVE1/SERVE2, sel updated, burst_cnt=0.
- State SERVEx:
  - inx_ready = load; the other input's ready = 0.
  - Transfer: inx_valid & inx_ready → out<=inx, out_valid<=1, burst_cnt++, rr_last<=x.
  - No transfer and load → out_valid<=0.
- Transitions out of SERVEx, evaluated every cycle with priority top-down:
  - burst_cnt reaches MAX_BURST on this transfer and the other input is valid → switch to SERVEy, burst_cnt<=0.
  - inx_valid low and the other input valid → switch to SERVEy.
  - Neither valid → IDLE.
  - Otherwise stay.
- A switch costs one bubble cycle: no transfer from the new owner in the switch cycle.
- Latency: valid rising in IDLE at cycle 0 → sel valid at cycle 1, accept at the end of cycle 1, out_valid at cycle 2.
- Backpressure: out_ready low with out_valid high → out, out_valid and burst_cnt hold; both readies low; state may still switch.
- Burst count only advances on actual transfers; stalls do not count.
- sel changes only on state transitions into SERVE1/SERVE2 and never glitches. It holds its last owner in IDLE.
- Reset mid-transfer: the in-flight word in out is discarded; the source must re-present it after reset.
- Handshake rule: upstream must not drop valid or change data while valid & ~ready. The block does not check this.

Optional Feature:
- Macro MUX2_ARB_STATS_EN.
- Defined: adds output ports cnt1 and cnt2, each 16 bits.
  - Each is a saturating count of accepted transfers from in1/in2; it holds at 16'hFFFF.
  - Both reset to 0 and are cleared by sys_rst only.
- Undefined: ports and counters absent; no other behaviour change.

Test Plan:
- Reset released, in1_valid=1 with in1=8'hA5, out_ready=1 → sel=1 at cycle 1, out=8'hA5 and out_valid=1 at cycle 2, in2_ready stays 0.
- Both valid continuously, out_ready=1, MAX_BURST=4 → out pattern is 4×in1, one bubble, 4×in2, one bubble, repeating; the first owner is in1.
- in1 streaming 10 words, out_ready toggling 1/0 each cycle → exactly 10 outputs in order, no duplicates, in1_ready low on every cycle where out_valid & ~out_ready.
- in2 owner with in2_valid dropping and in1_valid high → switch to SERVE1 next cycle, sel goes 0→1, burst_cnt restarts.
- sys_rst pulsed asynchronously while out_valid=1 mid-burst → out_valid=0, sel=1, state IDLE immediately, with no clock edge needed.
- With MUX2_ARB_STATS_EN: 70000 in1 transfers → cnt1=16'hFFFF, cnt2=0.

Source files
------------

// File: rtl/mux2_arb.sv
// ============================================================================
//  Module      : mux2_arb
//  Description : Round-robin arbiter for two valid/ready streams feeding one
//                registered output slot. Drives the select of the downstream
//                2:1 mux (sel: 1 = in1, 0 = in2). The owner keeps the slot for
//                at most MAX_BURST consecutive transfers while the other input
//                waits. Every ownership change costs one bubble cycle.
//                Optional macro MUX2_ARB_STATS_EN adds saturating 16-bit
//                per-source transfer counters cnt1/cnt2.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux2_arb #(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [DATA_W-1:0] in1,
  input  logic              in1_valid,
  output logic              in1_ready,
  input  logic [DATA_W-1:0] in2,
  input  logic              in2_valid,
  output logic              in2_ready,
  output logic              sel,
  output logic [DATA_W-1:0] out,
  output logic              out_valid,
  input  logic              out_ready
`ifdef MUX2_ARB_STATS_EN
  ,
  output logic [15:0]       cnt1,
  output logic [15:0]       cnt2
`endif
);

  localparam logic [7:0] c_max_burst = 8'(MAX_BURST);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SERVE1 = 2'd1,
    ST_SERVE2 = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_rr_last;    // 1 = in1 transferred last, 0 = in2
  logic        r_bubble;     // first cycle after an ownership switch
  logic [7:0]  r_burst_cnt;  // transfers by the current owner, saturates

  logic        w_load;
  logic        w_xfer1;
  logic        w_xfer2;
  logic        w_xfer;
  logic        w_own_valid;
  logic        w_oth_valid;
  logic        w_grant1;
  logic [7:0]  w_cnt_next;
  state_t      w_other_state;

  // The slot can take a new word when empty or when it drains this cycle.
  assign w_load = ~out_valid | out_ready;

  // Readies are low in reset, in IDLE, in the bubble cycle and under stall.
  assign in1_ready = ~sys_rst & (r_state == ST_SERVE1) & ~r_bubble & w_load;
  assign in2_ready = ~sys_rst & (r_state == ST_SERVE2) & ~r_bubble & w_load;

  assign w_xfer1 = in1_valid & in1_ready;
  assign w_xfer2 = in2_valid & in2_ready;
  assign w_xfer  = w_xfer1 | w_xfer2;

  assign w_own_valid   = (r_state == ST_SERVE1) ? in1_valid : in2_valid;
  assign w_oth_valid   = (r_state == ST_SERVE1) ? in2_valid : in1_valid;
  assign w_other_state = (r_state == ST_SERVE1) ? ST_SERVE2 : ST_SERVE1;

  // Tie goes to the input that did not transfer last; a lone valid wins.
  assign w_grant1 = in1_valid & (~in2_valid | ~r_rr_last);

  // Saturating so a long uncontested run still trips the limit later.
  assign w_cnt_next = (r_burst_cnt == c_max_burst) ? r_burst_cnt
                                                   : r_burst_cnt + 8'd1;

  // Arbitration state, output slot and round-robin history.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state     <= ST_IDLE;
      sel         <= 1'b1;
      out         <= '0;
      out_valid   <= 1'b0;
      r_burst_cnt <= 8'd0;
      r_rr_last   <= 1'b0;
      r_bubble    <= 1'b0;
    end else begin
      if (w_xfer1) begin
        out       <= in1;
        out_valid <= 1'b1;
        r_rr_last <= 1'b1;
      end else if (w_xfer2) begin
        out       <= in2;
        out_valid <= 1'b1;
        r_rr_last <= 1'b0;
      end else if (w_load) begin
        out_valid <= 1'b0;
      end

      r_bubble <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (in1_valid | in2_valid) begin
            r_state     <= w_grant1 ? ST_SERVE1 : ST_SERVE2;
            sel         <= w_grant1;
            r_burst_cnt <= 8'd0;
          end
        end
        ST_SERVE1, ST_SERVE2: begin
          if ((w_xfer && (w_cnt_next == c_max_burst) && w_oth_valid) ||
              (~w_own_valid && w_oth_valid)) begin
            r_state     <= w_other_state;
            sel         <= (r_state == ST_SERVE2);
            r_burst_cnt <= 8'd0;
            r_bubble    <= 1'b1;
          end else if (~w_own_valid) begin
            r_state <= ST_IDLE;
          end else if (w_xfer) begin
            r_burst_cnt <= w_cnt_next;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef MUX2_ARB_STATS_EN
  // Per-source accepted-transfer counters, saturating at all ones.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt1 <= 16'd0;
      cnt2 <= 16'd0;
    end else begin
      if (w_xfer1 && (cnt1 != 16'hFFFF)) begin
        cnt1 <= cnt1 + 16'd1;
      end
      if (w_xfer2 && (cnt2 != 16'hFFFF)) begin
        cnt2 <= cnt2 + 16'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire
